// File: rtl/mystic_zicsr_pkg.sv
// Shared definitions for the Zicsr execution unit and the CSR storage block.
package mystic_zicsr_pkg;

  // Read latency of the storage block; also sets its pipeline depth.
  localparam int unsigned CSR_RD_LATENCY = 4;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_DONE    = 2'd2
  } exec_state_e;

  // The immediate forms all have funct3[2] set.
  function automatic logic is_imm_variant(input logic [2:0] funct3);
    return funct3[2];
  endfunction

endpackage

// File: rtl/mystic_csr_alu.sv
// Combinational read-modify-write datapath: new CSR value, write intent and
// legality for one Zicsr instruction.
module mystic_csr_alu
  import mystic_zicsr_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [2:0]      funct3_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [4:0]      rs1_idx_i,
  input  logic [XLEN-1:0] operand_i,
  input  logic [XLEN-1:0] old_i,
  output logic [XLEN-1:0] new_o,
  output logic            wr_o,
  output logic            illegal_o
);

  logic bad_funct3;

  always_comb begin
    new_o      = operand_i;
    wr_o       = 1'b0;
    bad_funct3 = 1'b0;
    case (funct3_i)
      F3_CSRRW, F3_CSRRWI: begin
        new_o = operand_i;
        wr_o  = 1'b1;
      end
      F3_CSRRS, F3_CSRRSI: begin
        new_o = old_i | operand_i;
        wr_o  = (rs1_idx_i != 5'd0);
      end
      F3_CSRRC, F3_CSRRCI: begin
        new_o = old_i & ~operand_i;
        wr_o  = (rs1_idx_i != 5'd0);
      end
      default: bad_funct3 = 1'b1;
    endcase
  end

  // addr[11:10] == 2'b11 marks a read-only CSR; only a write makes it illegal.
  assign illegal_o = bad_funct3 | (wr_o & (csr_addr_i[11:10] == 2'b11));

endmodule

// File: rtl/mystic_csr_exec.sv
// Zicsr execution unit: issues a read to CSR storage, waits out its fixed
// latency, then writes back the modified value and returns the old one.
module mystic_csr_exec #(
  parameter int unsigned CSR_RD_LATENCY = mystic_zicsr_pkg::CSR_RD_LATENCY,
  parameter int unsigned XLEN           = 64
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            core_disable_n,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [4:0]      rs1_idx_i,
  input  logic [XLEN-1:0] rs1_data_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            illegal_o,
  output logic            zicsr_we_o,
  output logic [11:0]     zicsr_addr_o,
  output logic [XLEN-1:0] zicsr_din_o,
  input  logic [XLEN-1:0] zicsr_dout_i
);
  import mystic_zicsr_pkg::*;

  localparam int unsigned CW = (CSR_RD_LATENCY < 1) ? 1 : $clog2(CSR_RD_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(CSR_RD_LATENCY);

  exec_state_e     state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [11:0]     addr_q, addr_d;
  logic [4:0]      rs1_idx_q, rs1_idx_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] old_q, old_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            illegal_q, illegal_d;
  logic            we_q, we_d;
  logic [11:0]     zaddr_q, zaddr_d;
  logic [XLEN-1:0] din_q, din_d;

  logic            in_idle;
  logic [2:0]      sel_funct3;
  logic [11:0]     sel_addr;
  logic [4:0]      sel_idx;
  logic [XLEN-1:0] sel_data;
  logic [XLEN-1:0] sel_operand;
  logic [XLEN-1:0] alu_new;
  logic            alu_wr;
  logic            alu_illegal;

  // In IDLE the ALU judges the incoming instruction; afterwards the latched one.
  assign in_idle     = (state_q == ST_IDLE);
  assign sel_funct3  = in_idle ? funct3_i   : funct3_q;
  assign sel_addr    = in_idle ? csr_addr_i : addr_q;
  assign sel_idx     = in_idle ? rs1_idx_i  : rs1_idx_q;
  assign sel_data    = in_idle ? rs1_data_i : rs1_data_q;
  assign sel_operand = is_imm_variant(sel_funct3) ? {{(XLEN-5){1'b0}}, sel_idx} : sel_data;

  mystic_csr_alu #(
    .XLEN (XLEN)
  ) u_alu (
    .funct3_i   (sel_funct3),
    .csr_addr_i (sel_addr),
    .rs1_idx_i  (sel_idx),
    .operand_i  (sel_operand),
    .old_i      (zicsr_dout_i),
    .new_o      (alu_new),
    .wr_o       (alu_wr),
    .illegal_o  (alu_illegal)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    rs1_idx_d  = rs1_idx_q;
    rs1_data_d = rs1_data_q;
    old_d      = old_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    we_d       = 1'b0;
    zaddr_d    = zaddr_q;
    din_d      = '0;

    case (state_q)
      ST_IDLE: begin
        busy_d  = 1'b0;
        zaddr_d = '0;
        cnt_d   = '0;
        if (start_i) begin
          funct3_d   = funct3_i;
          addr_d     = csr_addr_i;
          rs1_idx_d  = rs1_idx_i;
          rs1_data_d = rs1_data_i;
          busy_d     = 1'b1;
          if (alu_illegal) begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            illegal_d = 1'b1;
            old_d     = '0;
          end else begin
            state_d = ST_RD_WAIT;
            cnt_d   = CNT_LOAD;
            zaddr_d = csr_addr_i;
          end
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == '0) begin
          old_d   = zicsr_dout_i;
          done_d  = 1'b1;
          we_d    = alu_wr;
          din_d   = alu_new;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        zaddr_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        zaddr_d = '0;
        cnt_d   = '0;
      end
    endcase

    // Storage is being cleared: drop any operation without writing or completing.
    if (!core_disable_n) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      illegal_d = 1'b0;
      we_d      = 1'b0;
      zaddr_d   = '0;
      din_d     = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      funct3_q   <= '0;
      addr_q     <= '0;
      rs1_idx_q  <= '0;
      rs1_data_q <= '0;
      old_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      we_q       <= 1'b0;
      zaddr_q    <= '0;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      rs1_idx_q  <= rs1_idx_d;
      rs1_data_q <= rs1_data_d;
      old_q      <= old_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
      we_q       <= we_d;
      zaddr_q    <= zaddr_d;
      din_q      <= din_d;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign rd_data_o    = old_q;
  assign illegal_o    = illegal_q;
  assign zicsr_we_o   = we_q;
  assign zicsr_addr_o = zaddr_q;
  assign zicsr_din_o  = din_q;

endmodule

// File: tb/tb_mystic_csr_exec.sv
// Scoreboard bench for mystic_csr_exec with a behavioural 4-cycle CSR storage.
module tb_mystic_csr_exec;

  localparam logic [2:0] W   = 3'b001;
  localparam logic [2:0] S   = 3'b010;
  localparam logic [2:0] C   = 3'b011;
  localparam logic [2:0] WI  = 3'b101;
  localparam logic [2:0] SI  = 3'b110;
  localparam logic [2:0] CI  = 3'b111;
  localparam logic [2:0] BAD = 3'b100;
  localparam int LEGAL_LAT   = 5;  // posedges after the accept edge until done is seen
  localparam int ILLEGAL_LAT = 0;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        core_dis_n = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [11:0] csr_addr = '0;
  logic [4:0]  rs1_idx = '0;
  logic [63:0] rs1_data = '0;
  logic        busy, done, illegal, we;
  logic [63:0] rd_data, zdin, zdout;
  logic [11:0] zaddr;

  logic        pre_en = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [63:0] pre_data = '0;
  logic [63:0] mem [4096];
  logic [63:0] pipe [4];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] rd;
    logic        ill;
    logic        we;
    logic [63:0] din;
    logic [11:0] addr;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  mystic_csr_exec dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .core_disable_n (core_dis_n),
    .start_i        (start),
    .funct3_i       (funct3),
    .csr_addr_i     (csr_addr),
    .rs1_idx_i      (rs1_idx),
    .rs1_data_i     (rs1_data),
    .busy_o         (busy),
    .done_o         (done),
    .rd_data_o      (rd_data),
    .illegal_o      (illegal),
    .zicsr_we_o     (we),
    .zicsr_addr_o   (zaddr),
    .zicsr_din_o    (zdin),
    .zicsr_dout_i   (zdout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Storage model: address sampled at an edge, data out four edges later.
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (we) mem[zaddr] <= zdin;
    pipe[0] <= mem[zaddr];
    for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
  end
  assign zdout = pipe[3];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (we && !done) chk("we_outside_done", {63'd0, we}, 64'd0);
    if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", {63'd0, done}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("done_latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
        chk("rd_data", rd_data, e.rd);
        chk("illegal", {63'd0, illegal}, {63'd0, e.ill});
        chk("we", {63'd0, we}, {63'd0, e.we});
        if (e.we) begin
          chk("din", zdin, e.din);
          chk("waddr", {52'd0, zaddr}, {52'd0, e.addr});
        end
      end
    end
  end

  task automatic preload(input logic [11:0] a, input logic [63:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_we"}, {63'd0, we}, 64'd0);
    chk({tag, "_addr"}, {52'd0, zaddr}, 64'd0);
    chk({tag, "_din"}, zdin, 64'd0);
    chk({tag, "_rd"}, rd_data, 64'd0);
    chk({tag, "_illegal"}, {63'd0, illegal}, 64'd0);
  endtask

  // mode 0: plain, 1: stray start pulses in cycles 2 and 4,
  // 2: reset in cycle 3, 3: core_disable_n low from cycle 3.
  task automatic do_op(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                       input logic [63:0] d, input logic [63:0] e_rd, input logic e_ill,
                       input logic e_we, input logic [63:0] e_din, input int mode);
    exp_t x;
    start = 1'b1; funct3 = f3; csr_addr = a; rs1_idx = idx; rs1_data = d;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
    if (mode < 2) begin
      x.rd = e_rd; x.ill = e_ill; x.we = e_we; x.din = e_din; x.addr = a;
      x.acc_cyc = cyc; x.lat = e_ill ? ILLEGAL_LAT : LEGAL_LAT;
      sb.push_back(x);
      for (int i = 1; i <= 20 && sb.size() != 0; i++) begin
        @(negedge clk);
        #1;
        if (mode == 1 && (i == 2 || i == 4)) begin
          start = 1'b1; funct3 = W; csr_addr = 12'h305; rs1_idx = 5'd7; rs1_data = 64'hAA;
        end else begin
          start = 1'b0;
        end
      end
      start = 1'b0;
      chk("op_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
      @(negedge clk);
    end else if (mode == 2) begin
      repeat (3) @(negedge clk);
      rstn = 1'b0;
      #1;
      chk_outputs_zero("async_reset");
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      repeat (10) @(negedge clk);
    end else begin
      repeat (3) @(negedge clk);
      core_dis_n = 1'b0;
      start = 1'b1;
      @(negedge clk);
      chk("disable_busy", {63'd0, busy}, 64'd0);
      chk("disable_addr", {52'd0, zaddr}, 64'd0);
      @(negedge clk);
      chk("disable_start_ignored", {63'd0, busy}, 64'd0);
      start = 1'b0;
      core_dis_n = 1'b1;
      repeat (10) @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rstn = 1'b1;
    preload(12'h300, 64'h1234);
    preload(12'h305, 64'hFF);
    preload(12'hC00, 64'h77);
    @(negedge clk);

    do_op(W,   12'h300, 5'd1,  64'hDEAD_BEEF, 64'h1234,      0, 1, 64'hDEAD_BEEF, 0);
    do_op(S,   12'h305, 5'd0,  64'h0,         64'hFF,        0, 0, 64'h0,         0);
    do_op(SI,  12'h305, 5'd5,  64'h0,         64'hFF,        0, 1, 64'hFF,        0);
    do_op(C,   12'h305, 5'd3,  64'h0F,        64'hFF,        0, 1, 64'hF0,        0);
    do_op(S,   12'h305, 5'd0,  64'h0,         64'hF0,        0, 0, 64'h0,         0);
    do_op(W,   12'hC00, 5'd1,  64'h9,         64'h0,         1, 0, 64'h0,         0);
    do_op(BAD, 12'h300, 5'd1,  64'h9,         64'h0,         1, 0, 64'h0,         0);
    do_op(CI,  12'hC00, 5'd0,  64'h0,         64'h77,        0, 0, 64'h0,         0);
    do_op(SI,  12'hC00, 5'd1,  64'h0,         64'h0,         1, 0, 64'h0,         0);
    do_op(W,   12'h300, 5'd2,  64'h55,        64'hDEAD_BEEF, 0, 1, 64'h55,        1);
    do_op(S,   12'h305, 5'd0,  64'h0,         64'hF0,        0, 0, 64'h0,         0);
    do_op(W,   12'h300, 5'd2,  64'h1111,      64'h0,         0, 0, 64'h0,         2);
    do_op(S,   12'h300, 5'd0,  64'h0,         64'h55,        0, 0, 64'h0,         0);
    do_op(W,   12'h305, 5'd2,  64'h2222,      64'h0,         0, 0, 64'h0,         3);
    do_op(S,   12'h305, 5'd0,  64'h0,         64'hF0,        0, 0, 64'h0,         0);
    do_op(WI,  12'h305, 5'd0,  64'hFFFF,      64'hF0,        0, 1, 64'h0,         0);
    do_op(S,   12'h305, 5'd0,  64'h0,         64'h0,         0, 0, 64'h0,         0);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
